// File: rtl/ppi_pkg.sv
// Shared constants and types for the PPI receive path: word width, receiver
// FSM states and the tagged FIFO entry.
package ppi_pkg;

    localparam int PPI_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } ppi_state_e;

    typedef struct packed {
        logic             sof;
        logic             eof;
        logic [PPI_W-1:0] data;
    } ppi_entry_t;

endpackage

// File: rtl/ppi_rx_if.sv
// PPI receive bundle: transmitter-side word bus in, tagged valid/ready stream
// and status pulses out.
interface ppi_rx_if;
    import ppi_pkg::*;

    logic             ppi_clk;
    logic             ppi_FS;
    logic [PPI_W-1:0] ppi_data;
    logic [PPI_W-1:0] rx_data;
    logic             rx_sof;
    logic             rx_eof;
    logic             rx_valid;
    logic             rx_ready;
    logic             frame_err;
    logic             overflow;

    // master drives the PPI word bus and consumes the stream
    modport master (
        output ppi_clk, ppi_FS, ppi_data, rx_ready,
        input  rx_data, rx_sof, rx_eof, rx_valid, frame_err, overflow
    );

    modport slave (
        input  ppi_clk, ppi_FS, ppi_data, rx_ready,
        output rx_data, rx_sof, rx_eof, rx_valid, frame_err, overflow
    );

endinterface

// File: rtl/ppi_rx_fifo.sv
// Single-clock FIFO of tagged PPI words; pointers carry an extra wrap bit so
// full and empty are told apart without a separate count.
module ppi_rx_fifo
    import ppi_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  ppi_entry_t wr_data,
    input  logic       rd_en,
    output ppi_entry_t rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    ppi_entry_t r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_wr;
    logic        w_do_rd;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A write into a full FIFO still lands when the head is popped that cycle.
    assign w_do_rd = rd_en & ~empty;
    assign w_do_wr = wr_en & (~full | w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Head is forced to zero while empty so the stream outputs read 0 after reset.
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/ppi_rx.sv
// PPI receiver: oversamples the PPI word bus on clk, rebuilds FRAME_LEN-word
// frames with sof/eof tags and buffers them for a valid/ready consumer.
module ppi_rx
    import ppi_pkg::*;
#(
    parameter int FRAME_LEN  = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    ppi_rx_if.slave     bus
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    logic             r_ppi_clk_q;
    logic             r_ppi_clk_q2;
    logic             r_ppi_fs_q;
    logic [PPI_W-1:0] r_ppi_data_q;
    ppi_state_e       r_state;
    ppi_state_e       w_state_next;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_next;
    logic             r_frame_err;
    logic             r_overflow;
    logic             w_wstb;
    logic             w_wr_en;
    logic             w_sof;
    logic             w_eof;
    logic             w_err;
    logic             w_rd_en;
    logic             w_full;
    logic             w_empty;
    ppi_entry_t       w_wr_entry;
    ppi_entry_t       w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ppi_clk_q  <= 1'b0;
            r_ppi_clk_q2 <= 1'b0;
            r_ppi_fs_q   <= 1'b0;
            r_ppi_data_q <= '0;
        end else begin
            r_ppi_clk_q  <= bus.ppi_clk;
            r_ppi_clk_q2 <= r_ppi_clk_q;
            r_ppi_fs_q   <= bus.ppi_FS;
            r_ppi_data_q <= bus.ppi_data;
        end
    end

    assign w_wstb = r_ppi_clk_q & ~r_ppi_clk_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (w_wstb) begin
            case (r_state)
                IDLE: begin
                    if (r_ppi_fs_q) begin
                        w_state_next = RECV;
                        w_cnt_next   = 8'd1;
                    end
                end
                RECV: begin
                    // A new FS restarts the frame; the aborted one never gets eof.
                    if (r_ppi_fs_q) begin
                        w_cnt_next = 8'd1;
                    end else if (r_cnt == LAST_IDX) begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_wr_en = 1'b0;
        w_sof   = 1'b0;
        w_eof   = 1'b0;
        w_err   = 1'b0;
        if (w_wstb) begin
            case (r_state)
                IDLE: begin
                    w_wr_en = r_ppi_fs_q;
                    w_sof   = r_ppi_fs_q;
                end
                RECV: begin
                    w_wr_en = 1'b1;
                    w_sof   = r_ppi_fs_q;
                    w_err   = r_ppi_fs_q;
                    w_eof   = ~r_ppi_fs_q & (r_cnt == LAST_IDX);
                end
                default: w_wr_en = 1'b0;
            endcase
        end
    end

    assign w_wr_entry = {w_sof, w_eof, r_ppi_data_q};
    assign w_rd_en    = ~w_empty & bus.rx_ready;

    ppi_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wr_en),
        .wr_data (w_wr_entry),
        .rd_en   (w_rd_en),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Dropped words still advance the FSM above, keeping frame alignment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= w_err;
            r_overflow  <= w_wr_en & w_full & ~w_rd_en;
        end
    end

    assign bus.rx_data   = w_head.data;
    assign bus.rx_sof    = w_head.sof;
    assign bus.rx_eof    = w_head.eof;
    assign bus.rx_valid  = ~w_empty;
    assign bus.frame_err = r_frame_err;
    assign bus.overflow  = r_overflow;

endmodule

// File: doc/ppi_rx.md
# ppi_rx

Receive side of the DSP parallel peripheral interface. It oversamples `ppi_clk`, `ppi_FS` and `ppi_data` from the PPI transmitter in the system clock domain, rebuilds fixed-length frames, and buffers words with start/end-of-frame tags in a small FIFO. Downstream logic drains that FIFO through a valid/ready stream. It sits directly downstream of the PPI transmit module, on the same `clk`.

## Interface
- `FRAME_LEN`, 16: words per frame, 2..256.
- `FIFO_DEPTH`, 16: FIFO entries, power of two, at least 4.
- `clk`  in  1  system clock; same clock that drives the PPI transmitter.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ppi_clk`  in  1  PPI word clock; it toggles no faster than `clk`/2.
- `ppi_FS`  in  1  frame sync; high with the first word of a frame.
- `ppi_data`  in  16  PPI word.
- `rx_data`  out  16  head-of-FIFO word.
- `rx_sof`  out  1  head word is the first word of a frame.
- `rx_eof`  out  1  head word is word `FRAME_LEN`-1 of a frame.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer accepts the head word.
- `frame_err`  out  1  one-cycle pulse: FS arrived before the current frame completed.
- `overflow`  out  1  one-cycle pulse: a word was dropped because the FIFO was full.

## Operation
- Input stage: `ppi_clk`, `ppi_FS` and `ppi_data` are registered every `clk` into `_q` copies. A second register `ppi_clk_q2` holds the previous `ppi_clk_q`.
- Strobe: `wstb = ppi_clk_q & ~ppi_clk_q2`. The captured word is `ppi_data_q`, and the captured sync is `ppi_FS_q`.
- FSM states:
  - IDLE: `wstb` with FS=0 discards the word. `wstb` with FS=1 writes the word with sof=1, sets the word counter to 1 and moves to RECV.
  - RECV, `wstb` with FS=0: writes the word. eof=1 when counter = `FRAME_LEN`-1; the counter then clears and the FSM returns to IDLE. Otherwise the counter increments.
  - RECV, `wstb` with FS=1 (short frame): `frame_err` pulses. The word is written with sof=1, the counter is set to 1 and the FSM stays in RECV. The aborted frame never carries eof.
- Word counter: 8 bits, never exceeds `FRAME_LEN`-1.
- FIFO write: on every `wstb` that the FSM accepts. If the FIFO is full and no read happens in the same cycle, the word is dropped and `overflow` pulses. The FSM and counter still advance, so frame alignment is kept.
- FIFO read: a pop happens when `rx_valid & rx_ready`.
- Full FIFO with write and read in the same cycle: both happen, no overflow.
- Empty FIFO: there is no write-to-output bypass.
- Reset (async, from any state): FSM = IDLE, counter = 0, FIFO pointers = 0, all input registers = 0.
- Reset values of outputs: `rx_valid`=0, `rx_sof`=0, `rx_eof`=0, `rx_data`=0, `frame_err`=0, `overflow`=0.
- Reset mid-frame: the partial frame is lost. After release, the next frame is accepted only when FS is seen.

## Timing
- Edge E0 is the first `clk` rising edge that samples `ppi_clk`=1.
- The FIFO write happens at E0+1. With the FIFO empty before that, `rx_valid` is high in the cycle after E0+1, so latency is 2 `clk` edges from the sampled `ppi_clk` rise.
- `frame_err` and `overflow` are registered and high for exactly the cycle after E0+1.
- `rx_data`, `rx_sof` and `rx_eof` are stable while `rx_valid`=1 and `rx_ready`=0.
- Sustained input is one word per 2 `clk` cycles. Output throughput is one word per cycle.

## Structure
- Package `ppi_pkg`: constant `PPI_W`=16, FSM state enum (IDLE, RECV), and the FIFO entry typedef {sof, eof, data[15:0]} of 18 bits.
- Sub-module `ppi_rx_fifo`:
  - synchronous single-clock FIFO, 18 bits wide, `FIFO_DEPTH` entries;
  - pointers are log2(`FIFO_DEPTH`)+1 bits, so full and empty are distinguished by the wrap bit;
  - provides `full`, `empty`, `wr_en`, `rd_en`.
- Top level holds the input registers, edge detect, FSM, counter and pulse outputs.

## Test plan
- Nominal frame: `ppi_clk`=`clk`/2, FS with word 0x0003 then words 0x0001, 0x0000 ×14, `rx_ready`=1 → 16 words out in order; sof only on 0x0003, eof only on word 16; `frame_err`=0; first `rx_valid` 2 edges after the sampled rise.
- Short frame: FS, 5 words, then FS again → `frame_err` pulses once; 6th word has sof=1; next 16 words form a complete frame with eof.
- Backpressure and overflow: `rx_ready`=0 for 20 input words, `FIFO_DEPTH`=16 → 16 words stored, 4 `overflow` pulses; release `rx_ready` → words 1..16 out; the next frame's sof lands on the correct word.
- Simultaneous read/write at full: FIFO full, `rx_ready`=1 and `wstb` in the same cycle → no `overflow`; occupancy stays 16.
- No FS: words without FS after reset → `rx_valid` stays 0.
- Async reset mid-frame at word 7 → all outputs 0 immediately; the post-release frame starting with FS is received intact.
